// File: rtl/cpu_pkg.sv
// Shared definitions for the 20-bit CPU: datapath widths, opcodes and the
// fetch-stage state encoding.
package cpu_pkg;

  localparam int unsigned INSTR_W = 20;
  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned OPC_W   = 5;

  localparam logic [OPC_W-1:0] OPC_HALT = 5'd0;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StValid,
    StDrain,
    StHalted
  } fetch_state_t;

endpackage

// File: rtl/program_counter.sv
// Architectural program counter with reset, load (redirect) and wrapping
// increment. Load takes priority over increment.
module program_counter #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_load_addr,
  input  logic              i_incr,
  output logic [ADDR_W-1:0] o_pc
);

  localparam logic [ADDR_W-1:0] RstPc = ADDR_W'(RESET_PC);

  logic [ADDR_W-1:0] r_pc;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pc <= RstPc;
    end else if (i_load) begin
      r_pc <= i_load_addr;
    end else if (i_incr) begin
      r_pc <= r_pc + ADDR_W'(1);
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: single-outstanding instruction memory reads, instruction
// register with valid/ready handoff to decode, redirect handling and halt.
module instruction_fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W   = cpu_pkg::ADDR_W,
  parameter int unsigned INSTR_W  = cpu_pkg::INSTR_W,
  parameter int unsigned RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_ack,
  output logic [INSTR_W-1:0] instruction,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               halt,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_addr,
  output logic               halted
);

  localparam logic [ADDR_W-1:0] RstPc = ADDR_W'(RESET_PC);

  fetch_state_t       r_state;
  logic [ADDR_W-1:0]  r_fetch_addr;
  logic [INSTR_W-1:0] r_ir;
  logic [ADDR_W-1:0]  r_instr_pc;
  logic               r_imem_req;
  logic               r_instr_valid;
  logic               r_halted;

  logic [ADDR_W-1:0]  w_pc;
  logic [ADDR_W-1:0]  w_instr_pc_inc;
  logic               w_pc_load;
  logic               w_pc_incr;

  // Redirects are honoured in every active state; IDLE and HALTED ignore them.
  assign w_pc_load = redirect &&
                     (r_state == StFetch || r_state == StValid || r_state == StDrain);
  assign w_pc_incr = (r_state == StValid) && instr_ready && !halt && !redirect;
  assign w_instr_pc_inc = r_instr_pc + ADDR_W'(1);

  program_counter #(
    .ADDR_W  (ADDR_W),
    .RESET_PC(RESET_PC)
  ) u_program_counter (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_load     (w_pc_load),
    .i_load_addr(redirect_addr),
    .i_incr     (w_pc_incr),
    .o_pc       (w_pc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= StIdle;
      r_fetch_addr  <= RstPc;
      r_ir          <= '0;
      r_instr_pc    <= RstPc;
      r_imem_req    <= 1'b0;
      r_instr_valid <= 1'b0;
      r_halted      <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          r_fetch_addr <= w_pc;
          r_imem_req   <= 1'b1;
          r_state      <= StFetch;
        end

        StFetch: begin
          if (redirect) begin
            if (imem_ack) begin
              // Current read finished; restart immediately at the target.
              r_fetch_addr <= redirect_addr;
            end else begin
              r_state <= StDrain;
            end
          end else if (imem_ack) begin
            r_ir          <= imem_rdata;
            r_instr_pc    <= r_fetch_addr;
            r_imem_req    <= 1'b0;
            r_instr_valid <= 1'b1;
            r_state       <= StValid;
          end
        end

        StDrain: begin
          if (imem_ack) begin
            // A redirect in the ack cycle is the newest target.
            r_fetch_addr <= redirect ? redirect_addr : w_pc;
            r_state      <= StFetch;
          end
        end

        StValid: begin
          if (redirect) begin
            r_fetch_addr  <= redirect_addr;
            r_instr_valid <= 1'b0;
            r_imem_req    <= 1'b1;
            r_state       <= StFetch;
          end else if (instr_ready && halt) begin
            r_instr_valid <= 1'b0;
            r_halted      <= 1'b1;
            r_state       <= StHalted;
          end else if (instr_ready) begin
            r_fetch_addr  <= w_instr_pc_inc;
            r_instr_valid <= 1'b0;
            r_imem_req    <= 1'b1;
            r_state       <= StFetch;
          end
        end

        StHalted: begin
          r_imem_req    <= 1'b0;
          r_instr_valid <= 1'b0;
          r_halted      <= 1'b1;
        end

        default: begin
          r_imem_req    <= 1'b0;
          r_instr_valid <= 1'b0;
          r_state       <= StIdle;
        end
      endcase
    end
  end

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_fetch_addr;
  assign instruction = r_ir;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_instr_valid;
  assign halted      = r_halted;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed plus randomized bench for instruction_fetch_unit with a
// variable-latency memory and an architectural-PC reference model.
module tb_instruction_fetch_unit;

  localparam int unsigned AW = 10;
  localparam int unsigned IW = 20;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_rdata;
  logic          imem_ack;
  logic [IW-1:0] instruction;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;
  logic          instr_ready;
  logic          halt;
  logic          redirect;
  logic [AW-1:0] redirect_addr;
  logic          halted;

  instruction_fetch_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_ack     (imem_ack),
    .instruction  (instruction),
    .instr_pc     (instr_pc),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .halt         (halt),
    .redirect     (redirect),
    .redirect_addr(redirect_addr),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  logic [IW-1:0] mem [1024];
  logic          busy = 1'b0;
  int            rem = 0;
  int            lat = 1;
  logic [AW-1:0] req_addr = '0;
  logic [AW-1:0] model_pc;
  logic [IW-1:0] held_instr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; afterwards the memory model reacts to the DUT's registered outputs.
  task automatic tick();
    @(posedge clk);
    #1;
    imem_rdata = IW'($urandom);
    if (imem_ack) begin
      imem_ack = 1'b0;
      busy     = 1'b0;
    end
    if (busy && !imem_req) busy = 1'b0;
    if (busy) begin
      check("imem_addr_stable", 32'(imem_addr), 32'(req_addr));
      rem--;
      if (rem == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = mem[req_addr];
      end
    end else if (imem_req === 1'b1) begin
      busy     = 1'b1;
      req_addr = imem_addr;
      rem      = lat;
    end
  endtask

  task automatic wait_valid(input string tag, input int max);
    int n = 0;
    while (instr_valid !== 1'b1 && n < max) begin
      tick();
      n++;
    end
    check(tag, 32'(instr_valid), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = IW'($urandom);
    mem[0] = 20'h0A5C3;

    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
    halt = 1'b0; redirect = 1'b0; redirect_addr = '0;
    repeat (3) tick();
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_instr", 32'(instruction), 32'd0);
    check("rst_instr_pc", 32'(instr_pc), 32'd0);

    // Reset and first fetch
    rst_n = 1'b1;
    check("first_cycle_no_req", 32'(imem_req), 32'd0);
    tick();
    check("second_cycle_req", 32'(imem_req), 32'd1);
    check("first_addr", 32'(imem_addr), 32'd0);
    tick();
    check("ack_cycle_not_valid", 32'(instr_valid), 32'd0);
    tick();
    check("first_valid", 32'(instr_valid), 32'd1);
    check("first_instr", 32'(instruction), 32'h0A5C3);
    check("first_pc", 32'(instr_pc), 32'd0);

    // Backpressure
    held_instr = instruction;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", 32'(instr_valid), 32'd1);
      check("bp_instr", 32'(instruction), 32'(held_instr));
      check("bp_pc", 32'(instr_pc), 32'd0);
      check("bp_no_req", 32'(imem_req), 32'd0);
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check("accept_req", 32'(imem_req), 32'd1);
    check("accept_addr", 32'(imem_addr), 32'd1);
    wait_valid("pc1_valid", 10);
    check("pc1_instr", 32'(instruction), 32'(mem[1]));
    check("pc1_pc", 32'(instr_pc), 32'd1);

    // Wrap-around
    redirect = 1'b1; redirect_addr = AW'(1023);
    tick();
    redirect = 1'b0;
    check("redir_req", 32'(imem_req), 32'd1);
    check("redir_addr_1023", 32'(imem_addr), 32'd1023);
    check("redir_drop_valid", 32'(instr_valid), 32'd0);
    wait_valid("pc1023_valid", 10);
    check("pc1023_instr", 32'(instruction), 32'(mem[1023]));
    check("pc1023_pc", 32'(instr_pc), 32'd1023);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check("wrap_addr", 32'(imem_addr), 32'd0);
    wait_valid("wrap_valid", 10);
    check("wrap_pc", 32'(instr_pc), 32'd0);

    // Redirect with a request in flight (3-cycle memory)
    lat = 3;
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check("inflight_addr", 32'(imem_addr), 32'd1);
    redirect = 1'b1; redirect_addr = AW'('h200);
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 10 && imem_ack !== 1'b1; i++) begin
      check("drain_req", 32'(imem_req), 32'd1);
      check("drain_old_addr", 32'(imem_addr), 32'd1);
      check("drain_no_valid", 32'(instr_valid), 32'd0);
      tick();
    end
    check("drain_ack_seen", 32'(imem_ack), 32'd1);
    tick();
    check("drain_no_valid_after", 32'(instr_valid), 32'd0);
    check("drain_new_addr", 32'(imem_addr), 32'h200);
    lat = 1;
    wait_valid("pc200_valid", 10);
    check("pc200_pc", 32'(instr_pc), 32'h200);
    check("pc200_instr", 32'(instruction), 32'(mem[10'h200]));

    // Redirect and accept in the same cycle
    redirect = 1'b1; redirect_addr = AW'('h050); instr_ready = 1'b1;
    tick();
    redirect = 1'b0; instr_ready = 1'b0;
    check("redir_accept_addr", 32'(imem_addr), 32'h050);
    check("redir_accept_dropped", 32'(instr_valid), 32'd0);
    wait_valid("pc50_valid", 10);
    check("pc50_pc", 32'(instr_pc), 32'h050);

    // Randomized traffic against the architectural PC model
    model_pc = AW'('h050);
    for (int i = 0; i < 600; i++) begin
      lat           = int'($urandom_range(1, 4));
      instr_ready   = 1'($urandom);
      redirect      = ($urandom_range(0, 7) == 0);
      redirect_addr = AW'($urandom);
      check("rand_not_halted", 32'(halted), 32'd0);
      if (instr_valid === 1'b1 && !redirect) begin
        check("rand_pc", 32'(instr_pc), 32'(model_pc));
        check("rand_instr", 32'(instruction), 32'(mem[model_pc]));
      end
      if (redirect) model_pc = redirect_addr;
      else if (instr_valid === 1'b1 && instr_ready) model_pc = model_pc + AW'(1);
      tick();
    end
    redirect = 1'b0; instr_ready = 1'b0; lat = 1;

    // Halt
    wait_valid("pre_halt_valid", 20);
    check("pre_halt_pc", 32'(instr_pc), 32'(model_pc));
    instr_ready = 1'b1; halt = 1'b1;
    tick();
    instr_ready = 1'b0; halt = 1'b0;
    check("halted_set", 32'(halted), 32'd1);
    check("halted_no_valid", 32'(instr_valid), 32'd0);
    for (int i = 0; i < 20; i++) begin
      redirect = (i % 4 == 0); redirect_addr = AW'('h123); instr_ready = 1'b1;
      tick();
      check("halted_no_req", 32'(imem_req), 32'd0);
      check("halted_stays", 32'(halted), 32'd1);
    end
    redirect = 1'b0; instr_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    check("reset_clears_halted", 32'(halted), 32'd0);
    check("reset_clears_instr", 32'(instruction), 32'd0);
    check("reset_pc", 32'(instr_pc), 32'd0);
    rst_n = 1'b1;
    tick();
    check("restart_req", 32'(imem_req), 32'd1);
    check("restart_addr", 32'(imem_addr), 32'd0);
    wait_valid("restart_valid", 10);
    check("restart_instr", 32'(instruction), 32'h0A5C3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
